// File: rtl/stepper_pkg.sv
// -----------------------------------------------------------------------------
// stepper_pkg
// Shared definitions for the stepper motion sequencer:
//   - state_t   : sequencer states (IDLE / SETTLE / RUN / HOLD)
//   - DIR_CW/CCW: direction encoding driven to the phase driver
//   - *_W_DEF   : default widths for step count, period and position
// -----------------------------------------------------------------------------
package stepper_pkg;

    localparam int STEP_W_DEF = 16;
    localparam int PER_W_DEF  = 20;
    localparam int POS_W_DEF  = 24;

    localparam logic DIR_CW  = 1'b0;  // forward, position counts up
    localparam logic DIR_CCW = 1'b1;  // reverse, position counts down

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

endpackage

// File: rtl/step_ramp_gen.sv
// -----------------------------------------------------------------------------
// step_ramp_gen
// Combinational trapezoid ramp step. Given the period just used, the cruise
// target, the number of acceleration steps taken so far and the steps still to
// go after the current pulse, returns the period for the next interval and the
// updated acceleration step count.
//   Deceleration has priority: once the remaining steps no longer exceed the
//   steps spent accelerating, the period grows back toward START_PERIOD.
// Ports:
//   cur_period  in  current step period (clk cycles)
//   target      in  cruise period
//   ramp_cnt    in  acceleration steps taken
//   n           in  steps remaining after this pulse
//   nxt_period  out period for the next interval
//   nxt_ramp    out updated acceleration step count
// -----------------------------------------------------------------------------
module step_ramp_gen #(
    parameter int STEP_W       = 16,
    parameter int PER_W        = 20,
    parameter int START_PERIOD = 50000,
    parameter int RAMP_DEC     = 500
) (
    input  logic [PER_W-1:0]  cur_period,
    input  logic [PER_W-1:0]  target,
    input  logic [STEP_W-1:0] ramp_cnt,
    input  logic [STEP_W-1:0] n,
    output logic [PER_W-1:0]  nxt_period,
    output logic [STEP_W-1:0] nxt_ramp
);

    localparam logic [PER_W:0] DEC_X   = (PER_W+1)'(RAMP_DEC);
    localparam logic [PER_W:0] START_X = (PER_W+1)'(START_PERIOD);

    // One extra bit so the +/- never wraps before the clamp is applied.
    logic [PER_W:0] up;
    logic [PER_W:0] down;

    assign up   = {1'b0, cur_period} + DEC_X;
    assign down = {1'b0, cur_period} - DEC_X;

    always_comb begin
        nxt_period = cur_period;
        nxt_ramp   = ramp_cnt;
        if (n <= ramp_cnt) begin
            nxt_period = (up > START_X) ? START_X[PER_W-1:0] : up[PER_W-1:0];
            if (ramp_cnt != '0) begin
                nxt_ramp = ramp_cnt - STEP_W'(1);
            end
        end else if (cur_period > target) begin
            // down[PER_W] set means the subtraction went below zero.
            if (down[PER_W] || (down[PER_W-1:0] < target)) begin
                nxt_period = target;
            end else begin
                nxt_period = down[PER_W-1:0];
            end
            nxt_ramp = ramp_cnt + STEP_W'(1);
        end
    end

endmodule

// File: rtl/stepper_motion_ctrl.sv
// -----------------------------------------------------------------------------
// stepper_motion_ctrl
// Motion sequencer in front of the stepper phase driver. Takes move commands,
// energises the driver, waits for it to settle, then emits one-cycle step
// strobes on a linear trapezoidal ramp while tracking absolute position.
//
// Command handshake: a command transfers on any rising clk edge where
// cmd_valid && cmd_ready are both high. cmd_ready is high only while the
// sequencer is IDLE or HOLD; cmd_steps/cmd_dir/cmd_period must be stable while
// cmd_valid is high. Commands offered while busy simply wait.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   cmd_valid/ready   command handshake
//   cmd_steps         steps to move (0 gives an immediate done, no motion)
//   cmd_dir           0 forward (+1 per step), 1 reverse (-1 per step)
//   cmd_period        cruise period in clk cycles (floored at MIN_PERIOD)
//   abort             level; stops an active move without decel
//   limit_fwd/rev     travel limits, checked for the current direction
//   motor_enable      driver energise (SETTLE/RUN/HOLD)
//   direction         latched direction
//   step_pulse        one-cycle step strobe
//   busy              high in SETTLE/RUN
//   done              one-cycle move-complete strobe
//   fault             sticky until next accepted command: stopped by limit
//   position          signed absolute step position (wraps)
//   steps_left        remaining steps of current move
//   state_dbg         current sequencer state (state_t encoding)
// -----------------------------------------------------------------------------
module stepper_motion_ctrl
    import stepper_pkg::*;
#(
    parameter int STEP_W        = STEP_W_DEF,
    parameter int PER_W         = PER_W_DEF,
    parameter int POS_W         = POS_W_DEF,
    parameter int START_PERIOD  = 50000,
    parameter int MIN_PERIOD    = 2,
    parameter int RAMP_DEC      = 500,
    parameter int SETTLE_CYCLES = 1000,
    parameter int HOLD_CYCLES   = 100000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [STEP_W-1:0]       cmd_steps,
    input  logic                    cmd_dir,
    input  logic [PER_W-1:0]        cmd_period,
    input  logic                    abort,
    input  logic                    limit_fwd,
    input  logic                    limit_rev,
    output logic                    motor_enable,
    output logic                    direction,
    output logic                    step_pulse,
    output logic                    busy,
    output logic                    done,
    output logic                    fault,
    output logic signed [POS_W-1:0] position,
    output logic [STEP_W-1:0]       steps_left,
    output logic [1:0]              state_dbg
);

    localparam int SET_W  = $clog2(SETTLE_CYCLES + 2);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 2);

    localparam logic [PER_W-1:0] MIN_P   = PER_W'(MIN_PERIOD);
    localparam logic [PER_W-1:0] START_P = PER_W'(START_PERIOD);

    state_t state, state_nxt;

    logic [PER_W-1:0]  target, cur_period, tick_cnt;
    logic [PER_W-1:0]  tgt, start_per, nxt_period;
    logic [STEP_W-1:0] ramp_cnt, nxt_ramp, n_after;
    logic [SET_W-1:0]  settle_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              finish_q;   // move is stopping; done/HOLD on next edge
    logic              zero_pend;  // zero-step command accepted; done next edge

    logic accept, zero_cmd, active, expire, lim_now;
    logic abort_hit, limit_hit, step_fire, settle_done;

    // Command decode: floor the target period, start the ramp at the slower
    // of the target and START_PERIOD.
    assign tgt       = (cmd_period < MIN_P) ? MIN_P : cmd_period;
    assign start_per = (tgt < START_P) ? START_P : tgt;

    assign cmd_ready    = (state == ST_IDLE) || (state == ST_HOLD);
    assign motor_enable = (state != ST_IDLE);
    assign busy         = active;
    assign state_dbg    = state;

    assign accept   = cmd_valid && cmd_ready;
    assign zero_cmd = (cmd_steps == '0);
    assign active   = (state == ST_SETTLE) || (state == ST_RUN);
    assign lim_now  = (direction == DIR_CCW) ? limit_rev : limit_fwd;

    // Abort outranks a coinciding tick expiry; a limit only suppresses a
    // pulse that was about to fire.
    assign expire      = (state == ST_RUN) && !finish_q && (tick_cnt <= PER_W'(1));
    assign abort_hit   = active && !finish_q && abort;
    assign limit_hit   = expire && !abort && lim_now;
    assign step_fire   = expire && !abort && !lim_now;
    assign settle_done = (state == ST_SETTLE) && !finish_q && !abort &&
                         (settle_cnt <= SET_W'(1));

    assign n_after = steps_left - STEP_W'(1);

    step_ramp_gen #(
        .STEP_W      (STEP_W),
        .PER_W       (PER_W),
        .START_PERIOD(START_PERIOD),
        .RAMP_DEC    (RAMP_DEC)
    ) u_ramp (
        .cur_period(cur_period),
        .target    (target),
        .ramp_cnt  (ramp_cnt),
        .n         (n_after),
        .nxt_period(nxt_period),
        .nxt_ramp  (nxt_ramp)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept && !zero_cmd) begin
                    state_nxt = (SETTLE_CYCLES == 0) ? ST_RUN : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (finish_q) begin
                    state_nxt = ST_HOLD;
                end else if (settle_done) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (finish_q) begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // Driver is still energised: only a direction change needs
                // the settle delay again. A command beats the hold timeout.
                if (accept) begin
                    if (!zero_cmd) begin
                        state_nxt = ((cmd_dir != direction) && (SETTLE_CYCLES != 0)) ?
                                    ST_SETTLE : ST_RUN;
                    end
                end else if (hold_cnt <= HOLD_W'(1)) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: counters, ramp registers, position and strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            direction  <= DIR_CW;
            step_pulse <= 1'b0;
            done       <= 1'b0;
            fault      <= 1'b0;
            position   <= '0;
            steps_left <= '0;
            target     <= '0;
            cur_period <= '0;
            tick_cnt   <= '0;
            ramp_cnt   <= '0;
            settle_cnt <= '0;
            hold_cnt   <= '0;
            finish_q   <= 1'b0;
            zero_pend  <= 1'b0;
        end else begin
            step_pulse <= 1'b0;
            done       <= 1'b0;

            if (zero_pend) begin
                done      <= 1'b1;
                zero_pend <= 1'b0;
            end

            if (accept) begin
                direction  <= cmd_dir;
                steps_left <= cmd_steps;
                target     <= tgt;
                cur_period <= start_per;
                tick_cnt   <= start_per;
                ramp_cnt   <= '0;
                fault      <= 1'b0;
                settle_cnt <= SET_W'(SETTLE_CYCLES);
                hold_cnt   <= HOLD_W'(HOLD_CYCLES);
                zero_pend  <= zero_cmd;
            end

            if (finish_q) begin
                done     <= 1'b1;
                finish_q <= 1'b0;
                hold_cnt <= HOLD_W'(HOLD_CYCLES);
            end else if (abort_hit) begin
                finish_q <= 1'b1;
            end else if (step_fire) begin
                step_pulse <= 1'b1;
                steps_left <= n_after;
                position   <= (direction == DIR_CW) ? position + POS_W'(1)
                                                    : position - POS_W'(1);
                cur_period <= nxt_period;
                ramp_cnt   <= nxt_ramp;
                tick_cnt   <= nxt_period;
                if (n_after == '0) begin
                    finish_q <= 1'b1;
                end
            end else if (limit_hit) begin
                fault    <= 1'b1;
                finish_q <= 1'b1;
            end else if (state == ST_RUN) begin
                tick_cnt <= tick_cnt - PER_W'(1);
            end else if (state == ST_SETTLE) begin
                settle_cnt <= settle_cnt - SET_W'(1);
            end else if ((state == ST_HOLD) && !accept && (hold_cnt != '0)) begin
                hold_cnt <= hold_cnt - HOLD_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_stepper_motion_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stepper_motion_ctrl
// Directed and randomized moves against a cycle-level model of the move
// timing (trapezoid computed step by step with integers), position and the
// HOLD window. Outputs are sampled 1 time unit after the falling edge.
// -----------------------------------------------------------------------------
module tb_stepper_motion_ctrl;

    localparam int STEP_W  = 16;
    localparam int PER_W   = 20;
    localparam int POS_W   = 24;
    localparam int START_P = 20;
    localparam int MIN_P   = 2;
    localparam int DEC     = 5;
    localparam int SETTLE  = 4;
    localparam int HOLD    = 8;

    localparam int S_IDLE = 0;
    localparam int S_HOLD = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic                    cmd_valid = 1'b0;
    logic                    cmd_ready;
    logic [STEP_W-1:0]       cmd_steps = '0;
    logic                    cmd_dir = 1'b0;
    logic [PER_W-1:0]        cmd_period = '0;
    logic                    abort = 1'b0;
    logic                    limit_fwd = 1'b0;
    logic                    limit_rev = 1'b0;
    logic                    motor_enable, direction, step_pulse, busy, done, fault;
    logic signed [POS_W-1:0] position;
    logic [STEP_W-1:0]       steps_left;
    logic [1:0]              state_dbg;

    stepper_motion_ctrl #(
        .STEP_W(STEP_W), .PER_W(PER_W), .POS_W(POS_W),
        .START_PERIOD(START_P), .MIN_PERIOD(MIN_P), .RAMP_DEC(DEC),
        .SETTLE_CYCLES(SETTLE), .HOLD_CYCLES(HOLD)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_steps(cmd_steps),
        .cmd_dir(cmd_dir), .cmd_period(cmd_period),
        .abort(abort), .limit_fwd(limit_fwd), .limit_rev(limit_rev),
        .motor_enable(motor_enable), .direction(direction), .step_pulse(step_pulse),
        .busy(busy), .done(done), .fault(fault), .position(position),
        .steps_left(steps_left), .state_dbg(state_dbg)
    );

    // ---------------- event capture ----------------
    int pulse_q[$];
    int done_q[$];
    always @(negedge clk) begin
        if (step_pulse === 1'b1) pulse_q.push_back(cyc);
        if (done === 1'b1) done_q.push_back(cyc);
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];   // expected pulse offsets from the accept edge
    int model_pos = 0;
    bit model_dir = 1'b0;
    int hold_end = -100;     // last edge at which the DUT is still in HOLD

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected pulse offsets for one move, straight from the ramp rules.
    task automatic model_times(input int steps, input int per, input bit settle);
        int t, cur, tgt, ramp, n;
        exp_q.delete();
        tgt  = (per < MIN_P) ? MIN_P : per;
        cur  = (tgt > START_P) ? tgt : START_P;
        t    = settle ? SETTLE : 0;
        ramp = 0;
        for (int i = 0; i < steps; i++) begin
            t += cur;
            exp_q.push_back(t);
            n = steps - 1 - i;
            if (n <= ramp) begin
                cur = (cur + DEC > START_P) ? START_P : cur + DEC;
                if (ramp > 0) ramp--;
            end else if (cur > tgt) begin
                cur = (cur - DEC < tgt) ? tgt : cur - DEC;
                ramp++;
            end
        end
    endtask

    function automatic int poff(input int idx, input int k);
        return (pulse_q.size() > idx) ? pulse_q[idx] - k : -1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send_cmd(input int steps, input bit dir, input int per, output int k);
        cmd_steps  = STEP_W'(steps);
        cmd_dir    = dir;
        cmd_period = PER_W'(per);
        cmd_valid  = 1'b1;
        tick();
        k = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int base, input int budget, output int d);
        int n;
        n = 0;
        while (done_q.size() <= base && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_done_seen"}, (done_q.size() > base), 1);
        d = (done_q.size() > base) ? done_q[base] : -1;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (state_dbg !== 2'(S_IDLE) && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_idle"}, state_dbg, S_IDLE);
    endtask

    task automatic run_move(input string tag, input int steps, input bit dir, input int per,
                            output int k, output int d, output int bp);
        int bd, npulse;
        bit in_hold, settle;
        bp = pulse_q.size();
        bd = done_q.size();
        send_cmd(steps, dir, per, k);
        in_hold   = (k <= hold_end);
        settle    = !(in_hold && dir == model_dir);
        model_dir = dir;
        check({tag, "_fault_clr"}, fault, 0);
        if (steps == 0) begin
            exp_q.delete();
            check({tag, "_ready0"}, cmd_ready, 1);
            wait_done(tag, bd, 20, d);
            check({tag, "_done_at"}, d - k, 1);
            check({tag, "_state0"}, state_dbg, in_hold ? S_HOLD : S_IDLE);
            if (in_hold) hold_end = k + HOLD;
        end else begin
            check({tag, "_busy"}, busy, 1);
            check({tag, "_en"}, motor_enable, 1);
            model_times(steps, per, settle);
            wait_done(tag, bd, int'(exp_q[$]) + 20, d);
            model_pos += dir ? -steps : steps;
            check({tag, "_done_at"}, d - k, int'(exp_q[$]) + 1);
            hold_end = k + int'(exp_q[$]) + 1 + HOLD;
            check({tag, "_pos"}, position, model_pos);
            check({tag, "_left"}, steps_left, 0);
        end
        npulse = pulse_q.size() - bp;
        check({tag, "_npulse"}, npulse, steps);
        for (int i = 0; i < steps && i < npulse; i++) begin
            check({tag, "_ptime"}, pulse_q[bp + i] - k, exp_q[i]);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int k, d, bp, bd, p0, prev, n;
        int iv[10] = '{20, 15, 10, 5, 5, 5, 5, 10, 15, 20};

        // Reset values
        repeat (3) tick();
        check("rst_ready", cmd_ready, 1);
        check("rst_en", motor_enable, 0);
        check("rst_busy", busy, 0);
        check("rst_pulse", step_pulse, 0);
        check("rst_done", done, 0);
        check("rst_fault", fault, 0);
        check("rst_pos", position, 0);
        check("rst_left", steps_left, 0);
        check("rst_dir", direction, 0);
        rst_n = 1'b1;
        tick();
        check("rst_state", state_dbg, S_IDLE);

        // 3 steps at cruise = START; the opposite limit is held high throughout
        limit_rev = 1'b1;
        run_move("mv3", 3, 1'b0, 20, k, d, bp);
        limit_rev = 1'b0;
        check("mv3_p1", poff(bp, k), 24);
        check("mv3_p2", poff(bp + 1, k), 44);
        check("mv3_p3", poff(bp + 2, k), 64);
        check("mv3_done", d - k, 65);
        check("mv3_pos3", position, 3);
        check("mv3_en_hold", motor_enable, 1);
        n = 0;
        while (cyc < d + 7 && n < 20) begin tick(); n++; end
        check("mv3_en_d7", motor_enable, 1);
        tick();
        check("mv3_en_d8", motor_enable, 0);
        check("mv3_ready_idle", cmd_ready, 1);

        // Full trapezoid
        bd = done_q.size();
        run_move("mv10", 10, 1'b0, 5, k, d, bp);
        prev = k + SETTLE;
        for (int i = 0; i < 10; i++) begin
            check("mv10_iv", (pulse_q.size() > bp + i) ? pulse_q[bp + i] - prev : -1, iv[i]);
            if (pulse_q.size() > bp + i) prev = pulse_q[bp + i];
        end
        repeat (3) tick();
        check("mv10_done_once", done_q.size() - bd, 1);
        check("mv10_pos", position, 13);

        // Direction change in HOLD needs SETTLE; same direction skips it
        wait_idle("dir");
        p0 = model_pos;
        run_move("dirA", 2, 1'b0, 20, k, d, bp);
        run_move("dirB", 2, 1'b1, 20, k, d, bp);
        check("dirB_first", poff(bp, k), 24);
        check("dirB_back", position, p0);
        run_move("dirC", 2, 1'b0, 20, k, d, bp);
        run_move("dirD", 2, 1'b0, 20, k, d, bp);
        check("dirD_first", poff(bp, k), 20);

        // HOLD window edge: accept on last HOLD edge, then one edge later
        repeat (7) tick();
        run_move("holdE", 2, 1'b0, 20, k, d, bp);
        check("holdE_first", poff(bp, k), 20);
        repeat (8) tick();
        run_move("holdF", 2, 1'b0, 20, k, d, bp);
        check("holdF_first", poff(bp, k), 24);

        // Zero-step command in HOLD
        run_move("zero", 0, 1'b0, 20, k, d, bp);

        // Forward limit after the 2nd pulse
        wait_idle("lim");
        bp = pulse_q.size();
        bd = done_q.size();
        send_cmd(5, 1'b0, 20, k);
        model_dir = 1'b0;
        model_times(5, 20, 1'b1);
        n = 0;
        while (pulse_q.size() < bp + 2 && n < 200) begin tick(); n++; end
        limit_fwd = 1'b1;
        wait_done("lim", bd, 200, d);
        model_pos += 2;
        hold_end = k + int'(exp_q[2]) + 1 + HOLD;
        check("lim_npulse", pulse_q.size() - bp, 2);
        check("lim_fault", fault, 1);
        check("lim_done_at", d - k, int'(exp_q[2]) + 1);
        check("lim_pos", position, model_pos);
        check("lim_left", steps_left, 3);
        run_move("lim_rev", 2, 1'b1, 20, k, d, bp);
        limit_fwd = 1'b0;

        // Abort on the 3rd tick-expiry edge
        wait_idle("abt");
        bp = pulse_q.size();
        send_cmd(5, 1'b0, 20, k);
        model_dir = 1'b0;
        model_times(5, 20, 1'b1);
        n = 0;
        while (cyc < k + int'(exp_q[2]) - 1 && n < 200) begin tick(); n++; end
        abort = 1'b1;
        tick();
        check("abt_no_pulse", step_pulse, 0);
        abort = 1'b0;
        tick();
        check("abt_done", done, 1);
        check("abt_state", state_dbg, S_HOLD);
        model_pos += 2;
        hold_end = cyc + HOLD;
        check("abt_pos", position, model_pos);
        check("abt_left", steps_left, 3);
        check("abt_npulse", pulse_q.size() - bp, 2);

        // Randomized moves
        for (int r = 0; r < 10; r++) begin
            repeat ($urandom_range(0, 12)) tick();
            run_move("rnd", int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 30)), k, d, bp);
        end

        // Reset mid-move
        wait_idle("rstm");
        bp = pulse_q.size();
        send_cmd(20, 1'b1, 20, k);
        n = 0;
        while (pulse_q.size() < bp + 2 && n < 200) begin tick(); n++; end
        #2 rst_n = 1'b0;
        #1;
        check("rstm_ready", cmd_ready, 1);
        check("rstm_en", motor_enable, 0);
        check("rstm_busy", busy, 0);
        check("rstm_pos", position, 0);
        check("rstm_left", steps_left, 0);
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        check("rstm_ready_rel", cmd_ready, 1);
        check("rstm_pos_rel", position, 0);
        check("rstm_state", state_dbg, S_IDLE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
